// File: rtl/qrs_peak_tracker.sv
// R-peak detector for one ECG channel: moving-average baseline removal, adaptive
// decaying threshold, QRS/refractory FSM and a one-entry valid/ready RR output.
module qrs_peak_tracker #(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned CTR_WIDTH   = 22,
  parameter int unsigned N_SHORT     = 16,
  parameter int unsigned LEARN_LEN   = 256,
  parameter int unsigned QRS_MAX     = 40,
  parameter int unsigned REFRACT_LEN = 72
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ce,
  input  logic signed [DATA_WIDTH-1:0] i_sample,
  input  logic                         i_sample_valid,
  output logic                         o_rr_valid,
  input  logic                         i_rr_ready,
  output logic [DATA_WIDTH-1:0]        o_rr_period,
  output logic [CTR_WIDTH-1:0]         o_r_peak_sample_num,
  output logic                         o_rr_dropped,
  output logic [DATA_WIDTH-1:0]        o_threshold,
  output logic [2:0]                   o_state
);

  localparam int unsigned LOG2N = $clog2(N_SHORT);
  localparam int unsigned SUM_W = DATA_WIDTH + LOG2N;
  localparam int unsigned CNT_W = $clog2(N_SHORT + LEARN_LEN + QRS_MAX + REFRACT_LEN + 1);
  localparam logic [DATA_WIDTH-1:0] FEAT_MAX = '1;

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_LEARN   = 3'd1,
    ST_SEARCH  = 3'd2,
    ST_QRS     = 3'd3,
    ST_REFRACT = 3'd4
  } state_e;

  logic signed [DATA_WIDTH-1:0] sr_q [N_SHORT];
  logic signed [DATA_WIDTH-1:0] sr_d [N_SHORT];
  logic [CTR_WIDTH-1:0]         idx_q, idx_d, s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
  logic [CTR_WIDTH-1:0]         f_idx_q, f_idx_d, pk_idx_q, pk_idx_d, prev_idx_q, prev_idx_d;
  logic [CTR_WIDTH-1:0]         new_idx_q, new_idx_d, rr_num_q, rr_num_d;
  logic signed [DATA_WIDTH-1:0] s1_new_q, s1_new_d, s1_old_q, s1_old_d, s2_smp_q, s2_smp_d;
  logic signed [SUM_W-1:0]      sum_q, sum_d;
  logic                         s1_v_q, s1_v_d, s2_v_q, s2_v_d, f_v_q, f_v_d;
  logic [DATA_WIDTH-1:0]        feat_q, feat_d, plev_q, plev_d, pk_q, pk_d;
  logic [DATA_WIDTH-1:0]        new_rr_q, new_rr_d, rr_period_q, rr_period_d;
  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [7:0]                   dec_q, dec_d;
  logic                         have_prev_q, have_prev_d, new_v_q, new_v_d;
  logic                         rr_valid_q, rr_valid_d, dropped_q, dropped_d;

  logic                         accept;
  logic signed [DATA_WIDTH-1:0] ma;
  logic signed [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]          mag;
  logic [DATA_WIDTH-1:0]        feat_c, thr, pk_new, dec_plev;
  logic [CTR_WIDTH-1:0]         pk_new_idx, rr_raw;
  logic                         fv, declare;

  assign accept = i_ce & i_sample_valid;
  assign thr    = plev_q >> 1;
  assign fv     = i_ce & f_v_q;

  // Sample pipeline: shift register/index, running sum, then |sample - ma| feature
  always_comb begin
    sr_d     = sr_q;
    idx_d    = idx_q;
    s1_v_d   = s1_v_q;
    s1_new_d = s1_new_q;
    s1_old_d = s1_old_q;
    s1_idx_d = s1_idx_q;
    sum_d    = sum_q;
    s2_v_d   = s2_v_q;
    s2_smp_d = s2_smp_q;
    s2_idx_d = s2_idx_q;
    f_v_d    = f_v_q;
    feat_d   = feat_q;
    f_idx_d  = f_idx_q;
    ma       = DATA_WIDTH'(sum_q >>> LOG2N);
    diff     = (DATA_WIDTH+1)'(s2_smp_q) - (DATA_WIDTH+1)'(ma);
    mag      = diff[DATA_WIDTH] ? -diff : diff;
    feat_c   = (mag > (DATA_WIDTH+1)'(FEAT_MAX)) ? FEAT_MAX : mag[DATA_WIDTH-1:0];
    if (i_ce) begin
      s1_v_d = i_sample_valid;
      s2_v_d = s1_v_q;
      f_v_d  = s2_v_q;
    end
    if (accept) begin
      sr_d[0] = i_sample;
      for (int i = 1; i < int'(N_SHORT); i++) sr_d[i] = sr_q[i-1];
      s1_new_d = i_sample;
      s1_old_d = sr_q[N_SHORT-1];
      s1_idx_d = idx_q;
      idx_d    = idx_q + CTR_WIDTH'(1);
    end
    if (i_ce && s1_v_q) begin
      sum_d    = sum_q + SUM_W'(s1_new_q) - SUM_W'(s1_old_q);
      s2_smp_d = s1_new_q;
      s2_idx_d = s1_idx_q;
    end
    if (i_ce && s2_v_q) begin
      feat_d  = feat_c;
      f_idx_d = s2_idx_q;
    end
  end

  // Detection FSM and peak-level tracking, advanced once per feature
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    plev_d      = plev_q;
    pk_d        = pk_q;
    pk_idx_d    = pk_idx_q;
    declare     = 1'b0;
    pk_new      = (feat_q > pk_q) ? feat_q : pk_q;
    pk_new_idx  = (feat_q > pk_q) ? f_idx_q : pk_idx_q;
    dec_plev    = plev_q - (plev_q >> 4);
    if (dec_plev == '0) dec_plev = DATA_WIDTH'(1);
    if (fv) begin
      unique case (state_q)
        ST_FILL: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_SHORT - 1)) begin
            cnt_d   = '0;
            state_d = ST_LEARN;
          end
        end
        ST_LEARN: begin
          if (feat_q > plev_q) plev_d = feat_q;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LEARN_LEN - 1)) begin
            cnt_d   = '0;
            dec_d   = '0;
            state_d = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (feat_q > thr) begin
            pk_d     = feat_q;
            pk_idx_d = f_idx_q;
            cnt_d    = '0;
            dec_d    = '0;
            state_d  = ST_QRS;
          end else begin
            dec_d = dec_q + 8'd1;
            if (dec_q == 8'hff) plev_d = dec_plev;
          end
        end
        ST_QRS: begin
          pk_d     = pk_new;
          pk_idx_d = pk_new_idx;
          cnt_d    = cnt_q + CNT_W'(1);
          if (feat_q <= thr || cnt_q == CNT_W'(QRS_MAX - 1)) begin
            declare = 1'b1;
            cnt_d   = '0;
            plev_d  = plev_q - (plev_q >> 3) + (pk_new >> 3);
            state_d = ST_REFRACT;
          end
        end
        ST_REFRACT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(REFRACT_LEN - 1)) begin
            cnt_d   = '0;
            dec_d   = '0;
            state_d = ST_SEARCH;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  // RR computation against the previous peak; the first peak only seeds prev_idx
  always_comb begin
    have_prev_d = have_prev_q;
    prev_idx_d  = prev_idx_q;
    new_v_d     = i_ce ? 1'b0 : new_v_q;
    new_rr_d    = new_rr_q;
    new_idx_d   = new_idx_q;
    rr_raw      = pk_new_idx - prev_idx_q;
    if (declare) begin
      have_prev_d = 1'b1;
      prev_idx_d  = pk_new_idx;
      if (have_prev_q) begin
        new_v_d   = 1'b1;
        new_idx_d = pk_new_idx;
        new_rr_d  = (rr_raw > CTR_WIDTH'(FEAT_MAX)) ? FEAT_MAX : DATA_WIDTH'(rr_raw);
      end
    end
  end

  // One-entry output register; a result arriving while a held result is stalled is dropped
  always_comb begin
    rr_valid_d  = rr_valid_q;
    rr_period_d = rr_period_q;
    rr_num_d    = rr_num_q;
    dropped_d   = 1'b0;
    if (rr_valid_q && i_rr_ready) rr_valid_d = 1'b0;
    if (i_ce && new_v_q) begin
      if (!rr_valid_q || i_rr_ready) begin
        rr_valid_d  = 1'b1;
        rr_period_d = new_rr_q;
        rr_num_d    = new_idx_q;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q        <= '{default: '0};
      idx_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_new_q    <= '0;
      s1_old_q    <= '0;
      s1_idx_q    <= '0;
      sum_q       <= '0;
      s2_v_q      <= 1'b0;
      s2_smp_q    <= '0;
      s2_idx_q    <= '0;
      f_v_q       <= 1'b0;
      feat_q      <= '0;
      f_idx_q     <= '0;
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      dec_q       <= '0;
      plev_q      <= '0;
      pk_q        <= '0;
      pk_idx_q    <= '0;
      have_prev_q <= 1'b0;
      prev_idx_q  <= '0;
      new_v_q     <= 1'b0;
      new_rr_q    <= '0;
      new_idx_q   <= '0;
      rr_valid_q  <= 1'b0;
      rr_period_q <= '0;
      rr_num_q    <= '0;
      dropped_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      s1_v_q      <= s1_v_d;
      s1_new_q    <= s1_new_d;
      s1_old_q    <= s1_old_d;
      s1_idx_q    <= s1_idx_d;
      sum_q       <= sum_d;
      s2_v_q      <= s2_v_d;
      s2_smp_q    <= s2_smp_d;
      s2_idx_q    <= s2_idx_d;
      f_v_q       <= f_v_d;
      feat_q      <= feat_d;
      f_idx_q     <= f_idx_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      plev_q      <= plev_d;
      pk_q        <= pk_d;
      pk_idx_q    <= pk_idx_d;
      have_prev_q <= have_prev_d;
      prev_idx_q  <= prev_idx_d;
      new_v_q     <= new_v_d;
      new_rr_q    <= new_rr_d;
      new_idx_q   <= new_idx_d;
      rr_valid_q  <= rr_valid_d;
      rr_period_q <= rr_period_d;
      rr_num_q    <= rr_num_d;
      dropped_q   <= dropped_d;
    end
  end

  assign o_rr_valid          = rr_valid_q;
  assign o_rr_period         = rr_period_q;
  assign o_r_peak_sample_num = rr_num_q;
  assign o_rr_dropped        = dropped_q;
  assign o_threshold         = thr;
  assign o_state             = 3'(state_q);

endmodule

// File: tb/tb_qrs_peak_tracker.sv
// Directed bench: default-parameter tracker for fill/learn/periodic/refractory/back-pressure/
// saturation/decay, plus a CTR_WIDTH=12 instance for index wrap.
module tb_qrs_peak_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, ce, vld_a, vld_b, rdy_a, rdy_b;
  logic signed [10:0] sample;
  logic               a_valid, a_drop, b_valid, b_drop;
  logic [10:0]        a_per, a_thr, b_per, b_thr;
  logic [21:0]        a_num;
  logic [11:0]        b_num;
  logic [2:0]         a_state, b_state;

  qrs_peak_tracker dut_a (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_sample(sample), .i_sample_valid(vld_a),
    .o_rr_valid(a_valid), .i_rr_ready(rdy_a), .o_rr_period(a_per),
    .o_r_peak_sample_num(a_num), .o_rr_dropped(a_drop), .o_threshold(a_thr), .o_state(a_state)
  );

  qrs_peak_tracker #(.CTR_WIDTH(12)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_sample(sample), .i_sample_valid(vld_b),
    .o_rr_valid(b_valid), .i_rr_ready(rdy_b), .o_rr_period(b_per),
    .o_r_peak_sample_num(b_num), .o_rr_dropped(b_drop), .o_threshold(b_thr), .o_state(b_state)
  );

  int checks = 0;
  int failures = 0;
  int q_per_a[$], q_num_a[$], q_per_b[$], q_num_b[$];
  int drops_a = 0;
  int drops_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Record every completed transfer and every drop pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && rdy_a) begin q_per_a.push_back(int'(a_per)); q_num_a.push_back(int'(a_num)); end
      if (b_valid && rdy_b) begin q_per_b.push_back(int'(b_per)); q_num_b.push_back(int'(b_num)); end
      if (a_drop) drops_a++;
      if (b_drop) drops_b++;
    end
  end

  function automatic int val_a(input int k);
    if (k >= 200 && k <= 2800 && (k % 200) == 0) return 800;
    if (k == 2050 || k == 5800) return 800;
    if (k == 9300) return 100;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_num_a[12] = '{600, 800, 1000, 1200, 1400, 1600, 1800, 2000, 2200, 2400, 2800, 5800};
  int exp_per_a[12] = '{200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 2047};

  initial begin
    rst = 1'b1; ce = 1'b1; vld_a = 1'b0; vld_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1; sample = '0;
    repeat (3) step();
    rst = 1'b0;

    check_eq("rst_valid", 32'(a_valid), 0);
    check_eq("rst_period", 32'(a_per), 0);
    check_eq("rst_num", 32'(a_num), 0);
    check_eq("rst_drop", 32'(a_drop), 0);
    check_eq("rst_thr", 32'(a_thr), 0);
    check_eq("rst_state", 32'(a_state), 0);

    for (int k = 0; k < 9400; k++) begin
      if (k == 18)   check_eq("fill_state", 32'(a_state), 0);
      if (k == 19)   check_eq("learn_state", 32'(a_state), 1);
      if (k == 19)   check_eq("fill_valid", 32'(a_valid), 0);
      if (k == 300) begin
        check_eq("search_state", 32'(a_state), 2);
        check_eq("learned_thr", 32'(a_thr), 375);
      end
      if (k == 2300) rdy_a = 1'b0;
      if (k == 2700) begin
        check_eq("bp_valid", 32'(a_valid), 1);
        check_eq("bp_period", 32'(a_per), 200);
        check_eq("bp_num", 32'(a_num), 2400);
        check_eq("bp_drops", 32'(drops_a), 1);
        rdy_a = 1'b1;
      end
      if (k == 5000) check_eq("decay8_thr", 32'(a_thr), 225);
      if (k == 9250) begin
        check_eq("decay13_thr", 32'(a_thr), 92);
        rdy_a = 1'b0;
      end
      sample = 11'(val_a(k));
      vld_a  = 1'b1;
      step();
      if (k == 1000) begin
        ce = 1'b0;
        repeat (10) step();
        ce = 1'b1;
      end
    end
    vld_a = 1'b0;
    sample = '0;
    repeat (20) step();
    check_eq("held_valid", 32'(a_valid), 1);
    check_eq("held_period", 32'(a_per), 2047);
    check_eq("held_num", 32'(a_num), 9300);

    for (int k = 0; k < 4300; k++) begin
      sample = (k == 200 || k == 4000 || k == 4200) ? 11'sd800 : 11'sd0;
      vld_b  = 1'b1;
      step();
    end
    vld_b = 1'b0;
    sample = '0;
    repeat (20) step();

    rst = 1'b1;
    step();
    check_eq("mid_rst_valid", 32'(a_valid), 0);
    check_eq("mid_rst_state", 32'(a_state), 0);
    check_eq("mid_rst_thr", 32'(a_thr), 0);
    check_eq("mid_rst_num", 32'(a_num), 0);
    check_eq("mid_rst_b_state", 32'(b_state), 0);
    rst = 1'b0;
    step();

    check_eq("a_count", 32'(q_per_a.size()), 12);
    for (int i = 0; i < 12 && i < q_per_a.size(); i++) begin
      check_eq($sformatf("a_per[%0d]", i), 32'(q_per_a[i]), 32'(exp_per_a[i]));
      check_eq($sformatf("a_num[%0d]", i), 32'(q_num_a[i]), 32'(exp_num_a[i]));
    end
    check_eq("a_drops", 32'(drops_a), 1);
    check_eq("b_count", 32'(q_per_b.size()), 1);
    if (q_per_b.size() > 0) begin
      check_eq("b_wrap_per", 32'(q_per_b[0]), 200);
      check_eq("b_wrap_num", 32'(q_num_b[0]), 104);
    end
    check_eq("b_drops", 32'(drops_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
